updown_step_decoder: RTL and testbench

Receive-side decoder for the up/down counter's value stream. Each valid sample of the 32-bit count is compared with the previous one, and the block recovers the 1-bit step instruction that produced it (0 = up, 1 = down). It also keeps up/down/run statistics and flags any illegal transition. It sits on the observer side of a counter instance and feeds trace logic and security checks that must confirm the counter only ever moved by ±1.

---
 rtl/updown_step_decoder.sv | 180 ++++++++++++++++++
 tb/tb_updown_step_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/updown_step_decoder.sv
// Observer-side decoder for an up/down counter's value stream: recovers each
// +/-1 step, keeps saturating statistics and flags illegal transitions.
module updown_step_decoder #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16,
  parameter int ERR_LIMIT = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 value_valid,
  input  logic [WIDTH-1:0]     value,
  input  logic                 clear,
  output logic                 inst_valid,
  output logic                 inst,
  output logic                 step_error,
  output logic                 error_sticky,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] up_count,
  output logic [CNT_WIDTH-1:0] down_count,
  output logic [CNT_WIDTH-1:0] run_length,
  output logic [1:0]           dbg_state
);

  localparam int EW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0]     DELTA_UP   = WIDTH'(1);
  localparam logic [WIDTH-1:0]     DELTA_DOWN = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [EW-1:0]        ERR_MAX    = EW'(ERR_LIMIT);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       prev_q, prev_d;
  logic                   inst_valid_q, inst_valid_d;
  logic                   inst_q, inst_d;
  logic                   step_error_q, step_error_d;
  logic                   error_sticky_q, error_sticky_d;
  logic [CNT_WIDTH-1:0]   up_count_q, up_count_d;
  logic [CNT_WIDTH-1:0]   down_count_q, down_count_d;
  logic [CNT_WIDTH-1:0]   run_length_q, run_length_d;
  logic [EW-1:0]          err_cnt_q, err_cnt_d;
  logic                   last_dir_q, last_dir_d;
  logic                   have_dir_q, have_dir_d;

  logic [WIDTH-1:0]       delta;
  logic                   legal_step;
  logic                   step_dir;

  // value_valid is a one-way qualifier: the block has no backpressure and
  // accepts every cycle where value_valid=1 and clear=0 (FAULT discards it).
  always_comb begin
    delta      = value - prev_q;
    legal_step = 1'b0;
    step_dir   = 1'b0;

    state_d        = state_q;
    prev_d         = prev_q;
    inst_valid_d   = 1'b0;
    inst_d         = inst_q;
    step_error_d   = 1'b0;
    error_sticky_d = error_sticky_q;
    up_count_d     = up_count_q;
    down_count_d   = down_count_q;
    run_length_d   = run_length_q;
    err_cnt_d      = err_cnt_q;
    last_dir_d     = last_dir_q;
    have_dir_d     = have_dir_q;

    if (clear) begin
      state_d        = ST_IDLE;
      error_sticky_d = 1'b0;
      up_count_d     = '0;
      down_count_d   = '0;
      run_length_d   = '0;
      err_cnt_d      = '0;
      have_dir_d     = 1'b0;
    end else if (value_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          prev_d  = value;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          prev_d = value;
          if (delta == DELTA_UP) begin
            legal_step = 1'b1;
            step_dir   = 1'b0;
          end else if (delta == DELTA_DOWN) begin
            legal_step = 1'b1;
            step_dir   = 1'b1;
          end else if (delta != '0) begin
            step_error_d   = 1'b1;
            error_sticky_d = 1'b1;
            run_length_d   = '0;
            have_dir_d     = 1'b0;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + EW'(1);
            end
            if (err_cnt_q + EW'(1) >= ERR_MAX) begin
              state_d = ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (legal_step) begin
        inst_valid_d = 1'b1;
        inst_d       = step_dir;
        err_cnt_d    = '0;
        last_dir_d   = step_dir;
        have_dir_d   = 1'b1;
        if (step_dir) begin
          if (down_count_q != CNT_MAX) down_count_d = down_count_q + CNT_ONE;
        end else begin
          if (up_count_q != CNT_MAX) up_count_d = up_count_q + CNT_ONE;
        end
        // A run continues only if the previous legal step went the same way
        // and no error or clear intervened since.
        if (have_dir_q && (last_dir_q == step_dir)) begin
          if (run_length_q != CNT_MAX) run_length_d = run_length_q + CNT_ONE;
        end else begin
          run_length_d = CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      prev_q         <= '0;
      inst_valid_q   <= 1'b0;
      inst_q         <= 1'b0;
      step_error_q   <= 1'b0;
      error_sticky_q <= 1'b0;
      up_count_q     <= '0;
      down_count_q   <= '0;
      run_length_q   <= '0;
      err_cnt_q      <= '0;
      last_dir_q     <= 1'b0;
      have_dir_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      inst_valid_q   <= inst_valid_d;
      inst_q         <= inst_d;
      step_error_q   <= step_error_d;
      error_sticky_q <= error_sticky_d;
      up_count_q     <= up_count_d;
      down_count_q   <= down_count_d;
      run_length_q   <= run_length_d;
      err_cnt_q      <= err_cnt_d;
      last_dir_q     <= last_dir_d;
      have_dir_q     <= have_dir_d;
    end
  end

  assign inst_valid   = inst_valid_q;
  assign inst         = inst_q;
  assign step_error   = step_error_q;
  assign error_sticky = error_sticky_q;
  assign fault        = (state_q == ST_FAULT);
  assign up_count     = up_count_q;
  assign down_count   = down_count_q;
  assign run_length   = run_length_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_updown_step_decoder.sv
// Directed bench for updown_step_decoder; small CNT_WIDTH so saturation is reachable.
module tb_updown_step_decoder;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 4;
  localparam int ERR_LIMIT = 3;

  logic                 clock;
  logic                 reset;
  logic                 value_valid;
  logic [WIDTH-1:0]     value;
  logic                 clear;
  logic                 inst_valid;
  logic                 inst;
  logic                 step_error;
  logic                 error_sticky;
  logic                 fault;
  logic [CNT_WIDTH-1:0] up_count;
  logic [CNT_WIDTH-1:0] down_count;
  logic [CNT_WIDTH-1:0] run_length;
  logic [1:0]           dbg_state;

  int checks;
  int errors;

  updown_step_decoder #(
    .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .ERR_LIMIT(ERR_LIMIT)
  ) dut (
    .clock(clock), .reset(reset), .value_valid(value_valid), .value(value),
    .clear(clear), .inst_valid(inst_valid), .inst(inst), .step_error(step_error),
    .error_sticky(error_sticky), .fault(fault), .up_count(up_count),
    .down_count(down_count), .run_length(run_length), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then look at outputs 1ns after the edge.
  task automatic drive(input logic rst_n, input logic vv, input logic [WIDTH-1:0] v,
                       input logic clr);
    reset       = rst_n;
    value_valid = vv;
    value       = v;
    clear       = clr;
    @(posedge clock);
    #1;
    reset       = 1'b1;
    value_valid = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic sample(input logic [WIDTH-1:0] v);
    drive(1'b1, 1'b1, v, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic chk_pulse(input string tag, input logic iv, input logic i, input logic se);
    check({tag, ".inst_valid"}, 32'(inst_valid), 32'(iv));
    check({tag, ".inst"}, 32'(inst), 32'(i));
    check({tag, ".step_error"}, 32'(step_error), 32'(se));
  endtask

  task automatic chk_stats(input string tag, input int up, input int dn, input int rl);
    check({tag, ".up_count"}, 32'(up_count), 32'(up));
    check({tag, ".down_count"}, 32'(down_count), 32'(dn));
    check({tag, ".run_length"}, 32'(run_length), 32'(rl));
  endtask

  task automatic chk_err(input string tag, input logic es, input logic f);
    check({tag, ".error_sticky"}, 32'(error_sticky), 32'(es));
    check({tag, ".fault"}, 32'(fault), 32'(f));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    value_valid = 1'b0;
    value       = '0;
    clear       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // reset state
    chk_pulse("rst", 1'b0, 1'b0, 1'b0);
    chk_err("rst", 1'b0, 1'b0);
    chk_stats("rst", 0, 0, 0);

    // 5,6,7,6
    sample(32'd5);  chk_pulse("t1_ref", 1'b0, 1'b0, 1'b0);
    sample(32'd6);  chk_pulse("t1_s6", 1'b1, 1'b0, 1'b0); chk_stats("t1_s6", 1, 0, 1);
    sample(32'd7);  chk_pulse("t1_s7", 1'b1, 1'b0, 1'b0); chk_stats("t1_s7", 2, 0, 2);
    sample(32'd6);  chk_pulse("t1_s6b", 1'b1, 1'b1, 1'b0); chk_stats("t1_s6b", 2, 1, 1);
    drive(1'b1, 1'b0, 32'd123, 1'b0);
    chk_pulse("t1_idle_hold", 1'b0, 1'b1, 1'b0); chk_stats("t1_idle", 2, 1, 1);

    // wrap-around
    do_clear(); chk_stats("t2_clr", 0, 0, 0);
    sample(32'hFFFF_FFFE); chk_pulse("t2_ref", 1'b0, 1'b1, 1'b0);
    sample(32'hFFFF_FFFF); chk_pulse("t2_up1", 1'b1, 1'b0, 1'b0);
    sample(32'h0000_0000); chk_pulse("t2_wrap_up", 1'b1, 1'b0, 1'b0); chk_stats("t2_wrap_up", 2, 0, 2);
    sample(32'hFFFF_FFFF); chk_pulse("t2_wrap_dn", 1'b1, 1'b1, 1'b0); chk_stats("t2_wrap_dn", 2, 1, 1);
    chk_err("t2", 1'b0, 1'b0);

    // stall
    do_clear();
    sample(32'd10); chk_pulse("t3_ref", 1'b0, 1'b1, 1'b0);
    sample(32'd10); chk_pulse("t3_stall", 1'b0, 1'b1, 1'b0); chk_stats("t3_stall", 0, 0, 0);
    sample(32'd11); chk_pulse("t3_up", 1'b1, 1'b0, 1'b0); chk_stats("t3_up", 1, 0, 1);

    // single error then resync
    do_clear();
    sample(32'd10);
    sample(32'd13); chk_pulse("t4_err", 1'b0, 1'b0, 1'b1); chk_err("t4_err", 1'b1, 1'b0);
    check("t4_err.run_length", 32'(run_length), 32'd0);
    sample(32'd14); chk_pulse("t4_resync", 1'b1, 1'b0, 1'b0); chk_err("t4_resync", 1'b1, 1'b0);
    chk_stats("t4_resync", 1, 0, 1);

    // error limit -> FAULT, then clear (with a discarded sample) and recover
    do_clear(); chk_err("t5_clr", 1'b0, 1'b0);
    sample(32'd0);
    sample(32'd5);  chk_pulse("t5_e1", 1'b0, 1'b0, 1'b1); chk_err("t5_e1", 1'b1, 1'b0);
    sample(32'd9);  chk_pulse("t5_e2", 1'b0, 1'b0, 1'b1); chk_err("t5_e2", 1'b1, 1'b0);
    sample(32'd20); chk_pulse("t5_e3", 1'b0, 1'b0, 1'b1); chk_err("t5_e3", 1'b1, 1'b1);
    sample(32'd21); chk_pulse("t5_ign", 1'b0, 1'b0, 1'b0); chk_err("t5_ign", 1'b1, 1'b1);
    drive(1'b1, 1'b1, 32'd50, 1'b1);
    chk_err("t5_clear", 1'b0, 1'b0); chk_pulse("t5_clear", 1'b0, 1'b0, 1'b0);
    sample(32'd21); chk_pulse("t5_ref", 1'b0, 1'b0, 1'b0);
    sample(32'd22); chk_pulse("t5_up", 1'b1, 1'b0, 1'b0); chk_stats("t5_up", 1, 0, 1);
    chk_err("t5_up", 1'b0, 1'b0);

    // errors interleaved with legal steps never reach the limit
    do_clear();
    sample(32'd0);
    sample(32'd7); sample(32'd9); sample(32'd10);
    sample(32'd3); sample(32'd8);
    chk_pulse("t6_e2", 1'b0, 1'b0, 1'b1); chk_err("t6_e2", 1'b1, 1'b0);
    sample(32'd9); chk_pulse("t6_up", 1'b1, 1'b0, 1'b0); chk_err("t6_up", 1'b1, 1'b0);

    // saturation at 2^CNT_WIDTH-1
    do_clear();
    sample(32'd0);
    for (int i = 1; i <= 18; i++) sample(32'(i));
    chk_stats("t7_sat", 15, 0, 15);

    // mid-stream reset with a concurrent sample
    do_clear();
    sample(32'd1);
    for (int i = 2; i <= 6; i++) sample(32'(i));
    chk_stats("t8_pre", 5, 0, 5);
    drive(1'b0, 1'b1, 32'd50, 1'b0);
    chk_pulse("t8_rst", 1'b0, 1'b0, 1'b0); chk_err("t8_rst", 1'b0, 1'b0);
    chk_stats("t8_rst", 0, 0, 0);
    sample(32'd100); chk_pulse("t8_ref", 1'b0, 1'b0, 1'b0);
    sample(32'd99);  chk_pulse("t8_dn", 1'b1, 1'b1, 1'b0); chk_stats("t8_dn", 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
